// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared definitions for the AXI4-Lite memory responder.
//               Holds the AXI response codes, the value returned for
//               out-of-range reads and the controller state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Returned as read data when an access misses the mapped window
    // (only reachable when AXI_MEM_SLVERR_EN is defined).
    localparam logic [31:0] SLVERR_FILL = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WR_WAIT    = 3'd2,
        RD_WAIT    = 3'd3,
        RD_RESP    = 3'd4,
        WR_RESP    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_array
// Description : Single-port synchronous RAM of 32-bit words with per-byte
//               write enables. The read data register updates every clock
//               from the addressed word (read-before-write on a collision).
// Ports       : clk            clock
//               addr  [AW-1:0] word index
//               we    [3:0]    byte write enables, bit i -> wdata[8i+7:8i]
//               wdata [31:0]   write data
//               rdata [31:0]   registered read data
// Revision    : 1.0  initial release
// ============================================================================
module axi_mem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_slave
// Description : AXI4-Lite responder memory, one transaction outstanding.
//               Writes win over reads when both are offered in IDLE. Read
//               data appears RD_LAT+1 cycles after the AR handshake; a
//               write commits WR_LAT+1 cycles after both AW and W are held.
//               Word index = ((addr - ADDR_BASE) >> 2) mod DEPTH_WORDS.
// Options     : AXI_MEM_SLVERR_EN - accesses outside
//               [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS) answer SLVERR, reads
//               return 32'hDEAD_BEEF and writes are discarded. Undefined:
//               addresses wrap and every response is OKAY.
// Ports       : clk, rst (async, active-high)
//               AR: s_araddr, s_arvalid, s_arready
//               R : s_rdata, s_rresp, s_rvalid, s_rready
//               AW: s_awaddr, s_awvalid, s_awready
//               W : s_wdata, s_wstrb, s_wvalid, s_wready
//               B : s_bresp, s_bvalid, s_bready
// Revision    : 1.0  initial release
// ============================================================================
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int CNT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;

    logic [IDX_W-1:0]   ar_idx;
    logic [IDX_W-1:0]   aw_idx;
    logic               ar_err;
    logic               aw_err;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               have_aw;
    logic               have_w;

    logic               ar_hs;
    logic               aw_hs;
    logic               w_hs;
    logic               commit;
    logic               rd_fire;
    logic               ar_err_d;
    logic               aw_err_d;

    logic [IDX_W-1:0]   ram_addr;
    logic [3:0]         ram_we;
    logic [31:0]        ram_rdata;

    assign ar_hs   = s_arvalid & s_arready;
    assign aw_hs   = s_awvalid & s_awready;
    assign w_hs    = s_wvalid  & s_wready;
    assign commit  = (state == WR_WAIT) && (cnt == WR_LAT_C);
    assign rd_fire = (state == RD_WAIT) && (cnt == RD_LAT_C);

`ifdef AXI_MEM_SLVERR_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    // Wrapping subtraction puts addresses below the base far above SPAN.
    assign ar_err_d = ({1'b0, s_araddr - ADDR_BASE} >= SPAN);
    assign aw_err_d = ({1'b0, s_awaddr - ADDR_BASE} >= SPAN);
`else
    assign ar_err_d = 1'b0;
    assign aw_err_d = 1'b0;
`endif

    // In IDLE the RAM is addressed straight from the AR bus so that the
    // word is already in the RAM output register on the cycle after the
    // handshake; this is what makes RD_LAT = 0 possible.
    always_comb begin
        ram_addr = aw_idx;
        if (state == IDLE) begin
            ram_addr = IDX_W'((s_araddr - ADDR_BASE) >> 2);
        end else if (state == RD_WAIT) begin
            ram_addr = ar_idx;
        end
    end

    assign ram_we = (commit && !aw_err) ? wstrb_q : 4'b0000;

    axi_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (IDX_W)
    ) u_mem (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_nxt = WR_WAIT;
                end else if (aw_hs || w_hs) begin
                    state_nxt = WR_COLLECT;
                end else if (ar_hs) begin
                    state_nxt = RD_WAIT;
                end
            end
            WR_COLLECT: begin
                if ((have_aw || aw_hs) && (have_w || w_hs)) begin
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (commit) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (rd_fire) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (channel readies). Gated by rst so they read 0 for the
    // whole reset interval, not just after the first edge.
    // ------------------------------------------------------------------
    always_comb begin
        s_arready = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    s_awready = 1'b1;
                    s_wready  = 1'b1;
                    s_arready = ~s_awvalid & ~s_wvalid;
                end
                WR_COLLECT: begin
                    s_awready = ~have_aw;
                    s_wready  = ~have_w;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: latency counter, captured request, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            ar_idx   <= '0;
            aw_idx   <= '0;
            ar_err   <= 1'b0;
            aw_err   <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            have_aw  <= 1'b0;
            have_w   <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
            s_rvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            s_bvalid <= 1'b0;
        end else begin
            if ((state == WR_WAIT && !commit) || (state == RD_WAIT && !rd_fire)) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            if (ar_hs) begin
                ar_idx <= IDX_W'((s_araddr - ADDR_BASE) >> 2);
                ar_err <= ar_err_d;
            end
            if (aw_hs) begin
                aw_idx  <= IDX_W'((s_awaddr - ADDR_BASE) >> 2);
                aw_err  <= aw_err_d;
                have_aw <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
                have_w  <= 1'b1;
            end

            if (commit) begin
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= aw_err ? RESP_SLVERR : RESP_OKAY;
            end else if (state == WR_RESP && s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (rd_fire) begin
                s_rvalid <= 1'b1;
                s_rdata  <= ar_err ? SLVERR_FILL : ram_rdata;
                s_rresp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
            end else if (state == RD_RESP && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_slave
// Description : Directed self-checking bench for axi_mem_slave with
//               RD_LAT=2, WR_LAT=1. Expected values are hand-computed.
//               Expectations for out-of-range accesses follow
//               AXI_MEM_SLVERR_EN when it is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef AXI_MEM_SLVERR_EN
    localparam logic [31:0] EXP_OOR_DATA   = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_OOR_RESP   = 32'd2;
    localparam logic [31:0] EXP_BASE_AFTER = 32'h0BAD_F00D;
`else
    localparam logic [31:0] EXP_OOR_DATA   = 32'h0BAD_F00D;
    localparam logic [31:0] EXP_OOR_RESP   = 32'd0;
    localparam logic [31:0] EXP_BASE_AFTER = 32'h1111_1111;
`endif

    always #5 clk = ~clk;

    axi_mem_slave #(
        .ADDR_BASE   (32'h8000_0000),
        .DEPTH_WORDS (4096),
        .RD_LAT      (2),
        .WR_LAT      (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // AW and W offered together; returns cycles from capture edge to bvalid.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int lat,
                             output logic [1:0] resp);
        int n;
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b1;
        #1;
        n = 0;
        while (!(s_awready && s_wready) && n < 20) begin
            tick();
            n++;
        end
        check("aw_w_accept", {30'd0, s_awready, s_wready}, 32'h3);
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_bvalid && lat < 20);
        check("bvalid_seen", {31'd0, s_bvalid}, 32'd1);
        resp = s_bresp;
        tick();
        check("b_done", {31'd0, s_bvalid}, 32'd0);
    endtask

    // Returns cycles from AR handshake edge to rvalid; holds rready low
    // for 'hold' cycles once rvalid is up, checking R stability.
    task automatic read_txn(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        int n;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        s_rready  = 1'b0;
        #1;
        n = 0;
        while (!s_arready && n < 20) begin
            tick();
            n++;
        end
        check("ar_accept", {31'd0, s_arready}, 32'd1);
        tick();
        s_arvalid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_rvalid && lat < 20);
        check("rvalid_seen", {31'd0, s_rvalid}, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_hold_valid", {31'd0, s_rvalid}, 32'd1);
            check("r_hold_data", s_rdata, data);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("r_done", {31'd0, s_rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [1:0]  resp;
        logic [31:0] data;

        rst       = 1'b1;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_readies", {29'd0, s_arready, s_awready, s_wready}, 32'h0);
        check("rst_valids", {30'd0, s_rvalid, s_bvalid}, 32'h0);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_resps", {28'd0, s_rresp, s_bresp}, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_readies", {29'd0, s_arready, s_awready, s_wready}, 32'h7);

        // Full-word write then read back, latencies 2 and 3
        write_txn(32'h8000_0010, 32'h1234_5678, 4'hF, lat, resp);
        check("wr1_lat", lat, 32'd2);
        check("wr1_bresp", {30'd0, resp}, 32'd0);
        read_txn(32'h8000_0010, 0, data, resp, lat);
        check("rd1_lat", lat, 32'd3);
        check("rd1_data", data, 32'h1234_5678);
        check("rd1_rresp", {30'd0, resp}, 32'd0);

        // Partial strobe 0101
        write_txn(32'h8000_0010, 32'hAABB_CCDD, 4'b0101, lat, resp);
        check("wr2_bresp", {30'd0, resp}, 32'd0);
        read_txn(32'h8000_0010, 0, data, resp, lat);
        check("rd2_data", data, 32'h12BB_56DD);

        // Empty strobe still responds, changes nothing; low addr bits ignored
        write_txn(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, lat, resp);
        check("wr_nostrb_lat", lat, 32'd2);
        check("wr_nostrb_bresp", {30'd0, resp}, 32'd0);
        read_txn(32'h8000_0013, 0, data, resp, lat);
        check("rd_nostrb_data", data, 32'h12BB_56DD);

        // W three cycles ahead of AW
        s_wdata   = 32'hCAFE_F00D;
        s_wstrb   = 4'hF;
        s_wvalid  = 1'b1;
        s_bready  = 1'b1;
        #1;
        check("t3_idle_ready", {30'd0, s_awready, s_wready}, 32'h3);
        tick();
        s_wvalid = 1'b0;
        check("t3_collect_c1", {29'd0, s_arready, s_awready, s_wready}, 32'h2);
        tick();
        check("t3_collect_c2", {29'd0, s_arready, s_awready, s_wready}, 32'h2);
        tick();
        check("t3_collect_c3", {29'd0, s_arready, s_awready, s_wready}, 32'h2);
        s_awaddr  = 32'h8000_0020;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("t3_aw_taken", {30'd0, s_awready, s_wready}, 32'h0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_bvalid && lat < 20);
        check("t3_b_lat", lat, 32'd2);
        tick();
        read_txn(32'h8000_0020, 0, data, resp, lat);
        check("t3_data", data, 32'hCAFE_F00D);

        // Simultaneous read and write: write first, B held 5 cycles
        s_araddr  = 32'h8000_0030;
        s_arvalid = 1'b1;
        s_awaddr  = 32'h8000_0030;
        s_wdata   = 32'h600D_CAFE;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b0;
        s_rready  = 1'b0;
        #1;
        check("t4_ar_blocked", {31'd0, s_arready}, 32'd0);
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("t4_ar_blocked_wait", {31'd0, s_arready}, 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_bvalid && lat < 20);
        check("t4_b_lat", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_b_hold", {29'd0, s_bvalid, s_bresp}, 32'h4);
            check("t4_ar_held_off", {31'd0, s_arready}, 32'd0);
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("t4_b_done", {31'd0, s_bvalid}, 32'd0);
        check("t4_ar_now_ready", {31'd0, s_arready}, 32'd1);
        tick();
        s_arvalid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_rvalid && lat < 20);
        check("t4_r_lat", lat, 32'd3);
        check("t4_r_data", s_rdata, 32'h600D_CAFE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_r_hold", {31'd0, s_rvalid}, 32'd1);
            check("t4_r_hold_data", s_rdata, 32'h600D_CAFE);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("t4_r_done", {31'd0, s_rvalid}, 32'd0);

        // Address window edges: wrap by depth and below-base accesses
        write_txn(32'h8000_0000, 32'h0BAD_F00D, 4'hF, lat, resp);
        read_txn(32'h8000_4000, 0, data, resp, lat);
        check("wrap_rd_data", data, EXP_OOR_DATA);
        check("wrap_rd_resp", {30'd0, resp}, EXP_OOR_RESP);
        check("wrap_rd_lat", lat, 32'd3);
        read_txn(32'h0000_0000, 0, data, resp, lat);
        check("low_rd_data", data, EXP_OOR_DATA);
        check("low_rd_resp", {30'd0, resp}, EXP_OOR_RESP);
        write_txn(32'h0000_0000, 32'h1111_1111, 4'hF, lat, resp);
        check("low_wr_lat", lat, 32'd2);
        check("low_wr_resp", {30'd0, resp}, EXP_OOR_RESP);
        read_txn(32'h8000_0000, 0, data, resp, lat);
        check("base_after_low_wr", data, EXP_BASE_AFTER);
        check("base_rd_resp", {30'd0, resp}, 32'd0);

        // Reset while the write is waiting to commit
        s_awaddr  = 32'h8000_0010;
        s_wdata   = 32'h5555_5555;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        rst = 1'b1;
        #1;
        check("wrst_readies", {29'd0, s_arready, s_awready, s_wready}, 32'h0);
        check("wrst_valids", {30'd0, s_rvalid, s_bvalid}, 32'h0);
        check("wrst_rdata", s_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        read_txn(32'h8000_0010, 0, data, resp, lat);
        check("wrst_old_data", data, 32'h12BB_56DD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Single-port AXI4-Lite responder memory at the far end of the CPU's external AXI master bus (AR/R/AW/W/B).
- Serves instruction fetches and data-cache refills/writebacks in simulation and FPGA builds.
- One transaction outstanding at a time; read and write latency are configurable.
- 32-bit words with byte strobes.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address mapped to word 0.
- DEPTH_WORDS, 4096, number of 32-bit words; power of two.
- RD_LAT, 2, extra wait cycles between AR handshake and rvalid (0 allowed).
- WR_LAT, 1, extra wait cycles between AW+W capture and commit (0 allowed).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_araddr  in  32  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address accept
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  master ready for read data
- s_awaddr  in  32  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address accept
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes; bit i enables wdata[8i+7:8i]
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data accept
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  master ready for write response

Behaviour:
- Reset is asynchronous and active-high:
  - All outputs go to 0: readies, valids, s_rdata, s_rresp, s_bresp.
  - FSM goes to IDLE and the latency counter is cleared.
  - Memory contents are not reset.
  - An in-flight transaction is dropped; a write whose commit cycle has not occurred is never applied.
- FSM states: IDLE, WR_COLLECT, WR_WAIT, RD_WAIT, RD_RESP, WR_RESP.
- IDLE:
  - s_awready=1 and s_wready=1.
  - s_arready = ~s_awvalid & ~s_wvalid, so a write wins on simultaneous requests.
  - AW and W may handshake together or separately.
  - If both are captured in the same cycle, go to WR_WAIT; if only one is captured, go to WR_COLLECT.
  - If AR handshakes, latch the address and go to RD_WAIT.
- WR_COLLECT:
  - Only the ready of the missing channel is high; s_arready=0.
  - When the second channel is captured, go to WR_WAIT.
- WR_WAIT:
  - Hold for WR_LAT cycles.
  - Commit cycle: for each set strobe bit, write that byte to mem[idx]; then set s_bvalid=1 and s_bresp=OKAY and go to WR_RESP.
  - A strobe of 4'b0000 commits nothing but still responds.
- WR_RESP: hold s_bvalid and s_bresp stable until s_bready=1; clear s_bvalid on that cycle and return to IDLE.
- RD_WAIT:
  - Hold for RD_LAT cycles.
  - Then load s_rdata from mem[idx], set s_rvalid=1 and s_rresp=OKAY, and go to RD_RESP.
  - s_rvalid rises exactly RD_LAT+1 cycles after the AR handshake cycle.
- RD_RESP:
  - s_rdata and s_rresp hold stable while s_rvalid & ~s_rready.
  - On the s_rready cycle, clear s_rvalid and return to IDLE; the next request is accepted the following cycle.
- Index: idx = ((addr - ADDR_BASE) >> 2) mod DEPTH_WORDS. Address bits [1:0] are ignored and the subtraction wraps at 32 bits.
- No read-after-write hazard exists: there is a single outstanding transaction and each write commits before its B response.

Optional Feature:
- Macro: AXI_MEM_SLVERR_EN.
- When defined:
  - An address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) returns s_rresp/s_bresp = SLVERR (2'b10).
  - Out-of-range reads return s_rdata=32'hDEAD_BEEF.
  - Out-of-range writes leave memory untouched.
  - Timing is identical to the in-range case.
- When undefined: all addresses wrap modulo the depth and every response is OKAY.

Decomposition:
- Package axi_pkg holds:
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The FSM state typedef.
  - The SLVERR fill constant 32'hDEAD_BEEF.
- Sub-module axi_mem_array: synchronous byte-enable RAM with one read/write port (addr, we[3:0], wdata, rdata), instantiated once.

Test Plan:
- Write 32'h1234_5678 to 32'h8000_0010 with strobe 4'hF, AW and W in the same cycle, bready=1 → bvalid rises 2 cycles after capture with bresp=00. Then read 32'h8000_0010 → rvalid 3 cycles after AR with rdata=32'h1234_5678.
- Same address, write 32'hAABB_CCDD with strobe 4'b0101 → subsequent read returns 32'h12BB_56DD.
- W presented 3 cycles before AW → wready drops after W capture, awready stays high until AW, and the commit uses both captured values.
- Simultaneous arvalid and awvalid/wvalid in IDLE → the write is served first (arready=0); the read is accepted only after the B handshake.
- Hold rready=0 for 5 cycles → rvalid and rdata stay stable; hold bready=0 similarly for B. With AXI_MEM_SLVERR_EN, a read of 32'h0000_0000 gives rresp=10 and rdata=32'hDEAD_BEEF.
- Assert rst in the WR_WAIT cycle → all outputs go to 0 immediately and a later read of that address returns the old data.
